// File: rtl/gouram_datatypes.sv
// Shared gouram types: trace record format, trace arbiter FSM states and defaults.
// Contents: trace_format record, arb_state_t, default arbiter sizing.
// Imported by the trace arbiter and its round-robin picker.
package gouram_datatypes;

  // One retired-instruction trace record as produced by a gouram WB tracker.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instruction;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic        mem_we;
    logic        mem_access;
  } trace_format;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam int GOURAM_ARB_DEFAULT_SOURCES = 2;
  localparam int GOURAM_ARB_DEFAULT_BURST   = 4;
  localparam int GOURAM_ARB_TS_W            = 32;

endpackage

// File: rtl/gouram_rr_picker.sv
// Combinational round-robin picker: first set bit of valid_i scanning from ptr_i upward, wrapping.
// Ports: valid_i (request vector), ptr_i (scan start) -> found_o (any request), idx_o (winner).
// Zero latency, no state; ptr_i must be < N.
module gouram_rr_picker
  import gouram_datatypes::*;
#(
  parameter int N = GOURAM_ARB_DEFAULT_SOURCES,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] valid_i,
  input  logic [W-1:0] ptr_i,
  output logic         found_o,
  output logic [W-1:0] idx_o
);

  always_comb begin
    int          j;
    logic [W-1:0] cand;
    found_o = 1'b0;
    idx_o   = '0;
    j       = 0;
    cand    = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr_i) + k;
      if (j >= N) j = j - N;
      cand = W'(j);
      if (!found_o && valid_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/gouram_trace_arbiter.sv
// Shares one trace sink between NUM_SOURCES gouram trace units: round-robin with bounded burst
// lock (MAX_BURST records per grant), one registered output stage, valid/ready on both sides.
// Ports: clk, rst (async, active-high); src_valid_i/src_record_i/src_ready_o per source;
//   sink_valid_o/sink_record_o/sink_src_id_o registered out, sink_ready_i back-pressure.
// Option GOURAM_ARB_TIMESTAMP_EN: adds sink_timestamp_o, the 32-bit cycle count at accept time.
module gouram_trace_arbiter
  import gouram_datatypes::*;
#(
  parameter  int NUM_SOURCES = GOURAM_ARB_DEFAULT_SOURCES,
  parameter  int MAX_BURST   = GOURAM_ARB_DEFAULT_BURST,
  localparam int SRC_ID_W    = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic        [NUM_SOURCES-1:0]   src_valid_i,
  input  trace_format [NUM_SOURCES-1:0]   src_record_i,
  output logic        [NUM_SOURCES-1:0]   src_ready_o,
  output logic                            sink_valid_o,
  output trace_format                     sink_record_o,
  output logic        [SRC_ID_W-1:0]      sink_src_id_o,
  input  logic                            sink_ready_i
`ifdef GOURAM_ARB_TIMESTAMP_EN
  ,
  output logic        [GOURAM_ARB_TS_W-1:0] sink_timestamp_o
`endif
);

  localparam int BCNT_W = $clog2(MAX_BURST + 1);

  arb_state_t            state_q, state_d;
  logic [SRC_ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [SRC_ID_W-1:0]   owner_q, owner_d;
  logic [BCNT_W-1:0]     burst_cnt_q, burst_cnt_d;
  logic                  sink_valid_q, sink_valid_d;
  trace_format           sink_record_q, sink_record_d;
  logic [SRC_ID_W-1:0]   sink_src_id_q, sink_src_id_d;

  logic                  pick_found;
  logic [SRC_ID_W-1:0]   pick_idx;
  logic                  out_free;
  logic                  cand_vld;
  logic [SRC_ID_W-1:0]   cand_idx;
  logic                  accept;

  function automatic logic [SRC_ID_W-1:0] ptr_inc(input logic [SRC_ID_W-1:0] p);
    if (p == SRC_ID_W'(NUM_SOURCES - 1)) return '0;
    return p + SRC_ID_W'(1);
  endfunction

  gouram_rr_picker #(
    .N (NUM_SOURCES),
    .W (SRC_ID_W)
  ) u_picker (
    .valid_i (src_valid_i),
    .ptr_i   (rr_ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  // Candidate selection: free scan in IDLE, the locked owner in BURST.
  always_comb begin
    out_free = !sink_valid_q || sink_ready_i;
    cand_idx = pick_idx;
    cand_vld = pick_found;
    if (state_q == BURST) begin
      cand_idx = owner_q;
      cand_vld = src_valid_i[owner_q];
    end
    // rst gates the handshake so no source believes a record was taken during reset.
    accept = cand_vld && out_free && !rst;
  end

  always_comb begin
    src_ready_o = '0;
    if (accept) src_ready_o[cand_idx] = 1'b1;
  end

  // Output register: load on accept, hold under stall, drop valid once drained.
  always_comb begin
    sink_valid_d  = sink_valid_q;
    sink_record_d = sink_record_q;
    sink_src_id_d = sink_src_id_q;
    if (accept) begin
      sink_valid_d  = 1'b1;
      sink_record_d = src_record_i[cand_idx];
      sink_src_id_d = cand_idx;
    end else if (sink_ready_i) begin
      sink_valid_d  = 1'b0;
    end
  end

  // Arbitration FSM.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          owner_d     = cand_idx;
          burst_cnt_d = BCNT_W'(1);
          if (MAX_BURST == 1) begin
            rr_ptr_d = ptr_inc(cand_idx);
          end else begin
            state_d  = BURST;
          end
        end
      end
      BURST: begin
        if (!src_valid_i[owner_q]) begin
          // Owner went quiet: release the lock; no grant is issued this cycle.
          state_d  = IDLE;
          rr_ptr_d = ptr_inc(owner_q);
        end else if (accept) begin
          burst_cnt_d = burst_cnt_q + BCNT_W'(1);
          if (burst_cnt_d == BCNT_W'(MAX_BURST)) begin
            state_d  = IDLE;
            rr_ptr_d = ptr_inc(owner_q);
          end
        end
        // Owner valid but sink stalled: everything holds.
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      owner_q       <= '0;
      burst_cnt_q   <= '0;
      sink_valid_q  <= 1'b0;
      sink_record_q <= '0;
      sink_src_id_q <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      owner_q       <= owner_d;
      burst_cnt_q   <= burst_cnt_d;
      sink_valid_q  <= sink_valid_d;
      sink_record_q <= sink_record_d;
      sink_src_id_q <= sink_src_id_d;
    end
  end

  assign sink_valid_o  = sink_valid_q;
  assign sink_record_o = sink_record_q;
  assign sink_src_id_o = sink_src_id_q;

`ifdef GOURAM_ARB_TIMESTAMP_EN
  logic [GOURAM_ARB_TS_W-1:0] ts_q, ts_d;
  logic [GOURAM_ARB_TS_W-1:0] sink_ts_q, sink_ts_d;

  // Free-running cycle counter; wraps naturally at 2^32. The value seen in the
  // accept cycle travels with the record.
  always_comb begin
    ts_d      = ts_q + GOURAM_ARB_TS_W'(1);
    sink_ts_d = sink_ts_q;
    if (accept) sink_ts_d = ts_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_q      <= '0;
      sink_ts_q <= '0;
    end else begin
      ts_q      <= ts_d;
      sink_ts_q <= sink_ts_d;
    end
  end

  assign sink_timestamp_o = sink_ts_q;
`endif

endmodule

// File: tb/tb_gouram_trace_arbiter.sv
// Self-checking bench for gouram_trace_arbiter (2 sources, burst 4): directed scenarios then
// random traffic, each cycle compared against a queue-free behavioural arbitration model.
// Summary line reports passed/total checks.
module tb_gouram_trace_arbiter;
  import gouram_datatypes::*;

  localparam int N  = 2;
  localparam int MB = 4;
  localparam int W  = 1;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [N-1:0]          src_valid_i;
  trace_format [N-1:0]   src_record_i;
  logic [N-1:0]          src_ready_o;
  logic                  sink_valid_o;
  trace_format           sink_record_o;
  logic [W-1:0]          sink_src_id_o;
  logic                  sink_ready_i;
`ifdef GOURAM_ARB_TIMESTAMP_EN
  logic [31:0]           sink_timestamp_o;
  int                    tb_cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) tb_cyc <= 0;
    else     tb_cyc <= tb_cyc + 1;
  end
`endif

  always #5 clk = ~clk;

  gouram_trace_arbiter #(
    .NUM_SOURCES (N),
    .MAX_BURST   (MB)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .src_valid_i   (src_valid_i),
    .src_record_i  (src_record_i),
    .src_ready_o   (src_ready_o),
    .sink_valid_o  (sink_valid_o),
    .sink_record_o (sink_record_o),
    .sink_src_id_o (sink_src_id_o),
    .sink_ready_i  (sink_ready_i)
`ifdef GOURAM_ARB_TIMESTAMP_EN
    ,
    .sink_timestamp_o (sink_timestamp_o)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic chk_rec(input string tag, input trace_format obs, input trace_format exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  // Behavioural model: owner < 0 means nobody holds the lock.
  int          m_ptr, m_owner, m_sent, m_id;
  logic        m_vld;
  trace_format m_rec;
  logic [31:0] m_ts;
  trace_format src_rec [N];

  function automatic trace_format new_rec();
    trace_format r;
    r.pc          = $urandom;
    r.instruction = $urandom;
    r.mem_addr    = $urandom;
    r.mem_be      = 4'($urandom_range(0, 15));
    r.mem_we      = 1'($urandom_range(0, 1));
    r.mem_access  = 1'($urandom_range(0, 1));
    return r;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_owner = -1; m_sent = 0; m_id = 0;
    m_vld = 1'b0; m_rec = '0; m_ts = '0;
  endtask

  // One cycle, entered and left at a negedge.
  task automatic step(input logic [N-1:0] v, input logic srdy);
    logic         free;
    int           cand;
    int           g;
    logic [N-1:0] exp_rdy;
    logic [31:0]  ts_at;
    for (int i = 0; i < N; i++) src_record_i[i] = src_rec[i];
    src_valid_i  = v;
    sink_ready_i = srdy;
    #1;
    free = !m_vld || srdy;
    cand = -1;
    g    = -1;
    if (m_owner < 0) begin
      for (int k = 0; k < N; k++)
        if (cand < 0 && v[(m_ptr + k) % N]) cand = (m_ptr + k) % N;
    end else if (v[m_owner]) begin
      cand = m_owner;
    end else begin
      m_ptr   = (m_owner + 1) % N;
      m_owner = -1;
    end
    exp_rdy = '0;
    if (cand >= 0 && free) begin
      exp_rdy[cand] = 1'b1;
      g = cand;
    end
    chk("src_ready", 32'(src_ready_o), 32'(exp_rdy));
    ts_at = '0;
`ifdef GOURAM_ARB_TIMESTAMP_EN
    ts_at = tb_cyc;
`endif
    @(posedge clk);
    #1;
    if (g >= 0) begin
      m_vld = 1'b1; m_rec = src_rec[g]; m_id = g; m_ts = ts_at;
      if (m_owner < 0) begin
        m_owner = g; m_sent = 1;
      end else begin
        m_sent++;
      end
      if (m_sent == MB) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end
      src_rec[g] = new_rec();
    end else if (srdy) begin
      m_vld = 1'b0;
    end
    chk("sink_valid", 32'(sink_valid_o), 32'(m_vld));
    if (m_vld) begin
      chk("sink_id", 32'(sink_src_id_o), 32'(m_id));
      chk_rec("sink_rec", sink_record_o, m_rec);
`ifdef GOURAM_ARB_TIMESTAMP_EN
      chk("sink_ts", sink_timestamp_o, m_ts);
`endif
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_valid", 32'(sink_valid_o), 32'd0);
    chk("rst_ready", 32'(src_ready_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    trace_format held;
    src_valid_i  = '0;
    sink_ready_i = 1'b1;
    for (int i = 0; i < N; i++) begin
      src_rec[i]      = new_rec();
      src_record_i[i] = src_rec[i];
    end
    model_reset();

    // Reset: outputs quiet even with requests pending.
    repeat (2) @(negedge clk);
    src_valid_i = '1;
    #1;
    chk("rst_ready_req", 32'(src_ready_o), 32'd0);
    chk("rst_valid0", 32'(sink_valid_o), 32'd0);
    chk("rst_id0", 32'(sink_src_id_o), 32'd0);
    chk_rec("rst_rec0", sink_record_o, '0);
    src_valid_i = '0;
    @(negedge clk);
    rst = 1'b0;

    // Idle for 20 cycles.
    repeat (20) step('0, 1'b1);

    // Both sources saturating: bursts of four alternate 0,1,0.
    for (int i = 0; i < 12; i++) begin
      step(2'b11, 1'b1);
      chk("rr_seq", 32'(sink_src_id_o), 32'((i / 4) % 2));
    end
    step('0, 1'b1);

    // Single record from src1 with pointer at 0; release wraps pointer back to 0.
    do_reset();
    step(2'b10, 1'b1);
    chk("single_id", 32'(sink_src_id_o), 32'd1);
    step(2'b00, 1'b1);
    step(2'b11, 1'b1);
    chk("ptr_wrap_id", 32'(sink_src_id_o), 32'd0);

    // Stall in the middle of src0's burst: output frozen, then burst completes at 4.
    step(2'b01, 1'b1);
    held = m_rec;
    for (int i = 0; i < 5; i++) begin
      step(2'b11, 1'b0);
      chk_rec("stall_hold", sink_record_o, held);
    end
    step(2'b11, 1'b1);
    step(2'b11, 1'b1);
    chk("burst_end_id", 32'(sink_src_id_o), 32'd0);
    step(2'b11, 1'b1);
    chk("rotate_id", 32'(sink_src_id_o), 32'd1);

    // Asynchronous reset while the output register is full.
    chk("pre_rst_valid", 32'(sink_valid_o), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_valid", 32'(sink_valid_o), 32'd0);
    chk("async_ready", 32'(src_ready_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step(2'b11, 1'b1);
    chk("post_rst_id", 32'(sink_src_id_o), 32'd0);

    // Random traffic and back-pressure.
    for (int i = 0; i < 400; i++)
      step(N'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
